// File: rtl/smps_pkg.sv
// Shared constants and state encoding for the SMPS PWM gate driver.
package smps_pkg;

    localparam int unsigned PERIOD_DEF   = 200;
    localparam int unsigned DEADTIME_DEF = 4;
    localparam int unsigned DUTY_MAX_DEF = PERIOD_DEF - 2 * DEADTIME_DEF;
    localparam int unsigned K_W          = 8;
    localparam int unsigned DUTY_W       = 8;
    localparam int unsigned GAP_W        = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HS_ON = 3'd1,
        DEAD1 = 3'd2,
        LS_ON = 3'd3,
        DEAD2 = 3'd4,
        FAULT = 3'd5
    } state_e;

endpackage

// File: rtl/smps_pwm_gate_if.sv
// Control/status bundle between the PWM controller and the gate driver.
interface smps_pwm_gate_if;
    import smps_pkg::*;

    logic              i_sw_clk;
    logic [DUTY_W-1:0] i_duty;
    logic              i_duty_valid;
    logic              i_fault;
    logic              i_fault_clr;
    logic              o_hs;
    logic              o_ls;
    logic              o_period_start;
    logic              o_fault;
    logic [DUTY_W-1:0] o_duty_active;

    modport master (
        output i_sw_clk, i_duty, i_duty_valid, i_fault, i_fault_clr,
        input  o_hs, o_ls, o_period_start, o_fault, o_duty_active
    );

    modport slave (
        input  i_sw_clk, i_duty, i_duty_valid, i_fault, i_fault_clr,
        output o_hs, o_ls, o_period_start, o_fault, o_duty_active
    );

endinterface

// File: rtl/sw_clk_edge_det.sv
// Rising-edge detector for the switching clock (same clock domain as i_clk).
module sw_clk_edge_det (
    input  logic i_clk,
    input  logic reset,
    input  logic i_sw_clk,
    output logic o_rise
);

    logic sw_d;
    logic sw_q;

    always_comb begin
        sw_d = i_sw_clk;
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            sw_q <= 1'b0;
        end else begin
            sw_q <= sw_d;
        end
    end

    assign o_rise = i_sw_clk & ~sw_q;

endmodule

// File: rtl/smps_pwm_gate.sv
// Half-bridge gate sequencer: HS on-time, dead times, LS on-time, latched fault.
module smps_pwm_gate
    import smps_pkg::*;
#(
    parameter int unsigned PERIOD   = PERIOD_DEF,
    parameter int unsigned DEADTIME = DEADTIME_DEF,
    parameter int unsigned DUTY_MAX = PERIOD - 2 * DEADTIME
) (
    input  logic            i_clk,
    input  logic            reset,
    smps_pwm_gate_if.slave  bus
);

    logic              rise;
    state_e            state_d, state_q, phase;
    logic [K_W-1:0]    k_d, k_q;
    logic [DUTY_W-1:0] shadow_d, shadow_q;
    logic [DUTY_W-1:0] duty_active_d, duty_active_q;
    logic [DUTY_W-1:0] duty_clamp;
    logic [GAP_W-1:0]  gap_d, gap_q;
    logic [K_W:0]      k_ext, d_ext;
    logic              hs_d, hs_q, ls_d, ls_q, ps_d, ps_q, fault_d, fault_q;

    sw_clk_edge_det u_edge (
        .i_clk    (i_clk),
        .reset    (reset),
        .i_sw_clk (bus.i_sw_clk),
        .o_rise   (rise)
    );

    // Outputs are registered from the next state, so they line up with k_q.
    always_comb begin
        state_d       = state_q;
        k_d           = (k_q == {K_W{1'b1}}) ? k_q : k_q + K_W'(1);
        shadow_d      = shadow_q;
        duty_active_d = duty_active_q;
        duty_clamp    = (bus.i_duty > DUTY_W'(DUTY_MAX)) ? DUTY_W'(DUTY_MAX) : bus.i_duty;

        if (bus.i_duty_valid) begin
            shadow_d = duty_clamp;
        end
        if (rise) begin
            k_d           = '0;
            duty_active_d = bus.i_duty_valid ? duty_clamp : shadow_q;
        end

        // gap_q counts cycles LS has been low; HS is held off until it reaches DEADTIME
        k_ext = {1'b0, k_d};
        d_ext = {1'b0, duty_active_d};
        if (k_ext < d_ext) begin
            phase = (gap_q >= GAP_W'(DEADTIME)) ? HS_ON : DEAD1;
        end else if (k_ext < d_ext + (K_W+1)'(DEADTIME)) begin
            phase = DEAD1;
        end else if (k_ext < (K_W+1)'(PERIOD - DEADTIME)) begin
            phase = LS_ON;
        end else begin
            phase = DEAD2;
        end

        unique case (state_q)
            IDLE:    if (rise) state_d = phase;
            FAULT:   if (bus.i_fault_clr && !bus.i_fault) state_d = IDLE;
            default: state_d = phase;
        endcase
        if (bus.i_fault) begin
            state_d = FAULT;
        end

        if (state_d == LS_ON) begin
            gap_d = '0;
        end else begin
            gap_d = (gap_q >= GAP_W'(DEADTIME)) ? gap_q : gap_q + GAP_W'(1);
        end

        hs_d    = (state_d == HS_ON);
        ls_d    = (state_d == LS_ON);
        fault_d = (state_d == FAULT);
        ps_d    = rise && (state_d != FAULT);
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            state_q       <= IDLE;
            k_q           <= '0;
            shadow_q      <= '0;
            duty_active_q <= '0;
            gap_q         <= GAP_W'(DEADTIME);
            hs_q          <= 1'b0;
            ls_q          <= 1'b0;
            ps_q          <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            shadow_q      <= shadow_d;
            duty_active_q <= duty_active_d;
            gap_q         <= gap_d;
            hs_q          <= hs_d;
            ls_q          <= ls_d;
            ps_q          <= ps_d;
            fault_q       <= fault_d;
        end
    end

    assign bus.o_hs           = hs_q;
    assign bus.o_ls           = ls_q;
    assign bus.o_period_start = ps_q;
    assign bus.o_fault        = fault_q;
    assign bus.o_duty_active  = duty_active_q;

endmodule

// File: tb/tb_smps_pwm_gate.sv
// Self-checking bench for smps_pwm_gate: duty table plus fault, early-edge and reset sequences.
module tb_smps_pwm_gate;

    localparam int PER = 200;
    localparam int DT  = 4;

    typedef struct packed {
        logic       rst;
        logic       sw;
        logic       dv;
        logic [7:0] d;
        logic       fault;
        logic       clr;
    } in_t;

    typedef struct packed {
        logic       hs;
        logic       ls;
        logic       ps;
        logic       fault;
        logic [7:0] duty;
    } out_t;

    typedef struct {
        logic [7:0] duty_in;
        logic [7:0] exp_duty;
        bit         at_edge;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    out_t exp_q[$];

    smps_pwm_gate_if bus();

    smps_pwm_gate dut (
        .i_clk (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic in_t mk_in(logic r, logic sw, logic dv, logic [7:0] d, logic f, logic c);
        in_t i;
        i.rst = r; i.sw = sw; i.dv = dv; i.d = d; i.fault = f; i.clr = c;
        return i;
    endfunction

    function automatic out_t run_exp(int k, logic [7:0] d);
        out_t e;
        e.hs    = (k < int'(d));
        e.ls    = (k >= int'(d) + DT) && (k < PER - DT);
        e.ps    = (k == 0);
        e.fault = 1'b0;
        e.duty  = d;
        return e;
    endfunction

    function automatic out_t idle_exp(logic [7:0] d, logic f);
        out_t e;
        e.hs = 1'b0; e.ls = 1'b0; e.ps = 1'b0; e.fault = f; e.duty = d;
        return e;
    endfunction

    task automatic step(input in_t i, input out_t e, input string tag, input int k);
        out_t got, want;
        rst              = i.rst;
        bus.i_sw_clk     = i.sw;
        bus.i_duty_valid = i.dv;
        bus.i_duty       = i.d;
        bus.i_fault      = i.fault;
        bus.i_fault_clr  = i.clr;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got.hs    = bus.o_hs;
        got.ls    = bus.o_ls;
        got.ps    = bus.o_period_start;
        got.fault = bus.o_fault;
        got.duty  = bus.o_duty_active;
        want      = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s k=%0d got hs=%b ls=%b ps=%b flt=%b duty=%0d expected hs=%b ls=%b ps=%b flt=%b duty=%0d",
                     tag, k, got.hs, got.ls, got.ps, got.fault, got.duty,
                     want.hs, want.ls, want.ps, want.fault, want.duty);
        end
    endtask

    // One full switching period: sw high for the first half, optional duty load at load_step.
    task automatic run_period(input logic [7:0] d_exp, input logic do_load,
                              input logic [7:0] load_val, input int load_step, input string tag);
        for (int j = 0; j < PER; j++) begin
            step(mk_in(1'b0, j < PER / 2, do_load && (j == load_step), load_val, 1'b0, 1'b0),
                 run_exp(j, d_exp), tag, j);
        end
    endtask

    initial begin
        vec_t       vecs[7];
        logic [7:0] cur;
        out_t       e;

        vecs[0] = '{duty_in: 8'd100, exp_duty: 8'd100, at_edge: 1'b0};
        vecs[1] = '{duty_in: 8'd60,  exp_duty: 8'd60,  at_edge: 1'b0};
        vecs[2] = '{duty_in: 8'd250, exp_duty: 8'd192, at_edge: 1'b0};
        vecs[3] = '{duty_in: 8'd0,   exp_duty: 8'd0,   at_edge: 1'b0};
        vecs[4] = '{duty_in: 8'd193, exp_duty: 8'd192, at_edge: 1'b0};
        vecs[5] = '{duty_in: 8'd1,   exp_duty: 8'd1,   at_edge: 1'b1};
        vecs[6] = '{duty_in: 8'd191, exp_duty: 8'd191, at_edge: 1'b0};

        for (int j = 0; j < 2; j++) step(mk_in(1, 0, 0, 8'd0, 0, 0), idle_exp(8'd0, 0), "reset", j);
        for (int j = 0; j < 5; j++) step(mk_in(0, 0, 0, 8'd0, 0, 0), idle_exp(8'd0, 0), "idle", j);

        // Each vector is loaded mid-period and must only take effect at the next edge.
        cur = 8'd0;
        for (int v = 0; v < 7; v++) begin
            if (vecs[v].at_edge) begin
                run_period(cur, 1'b0, 8'd0, 0, "pre_bypass");
                run_period(vecs[v].exp_duty, 1'b1, vecs[v].duty_in, 0, "bypass");
            end else begin
                run_period(cur, 1'b1, vecs[v].duty_in, 120, "table");
            end
            cur = vecs[v].exp_duty;
        end
        run_period(cur, 1'b1, 8'd100, 120, "table_last");
        cur = 8'd100;

        // Fault at k=50, clear ignored while fault held, clear accepted later.
        for (int j = 0; j < PER; j++) begin
            if (j <= 50) begin
                step(mk_in(0, j < 100, 0, 8'd0, 0, 0), run_exp(j, cur), "pre_fault", j);
            end else if (j <= 60) begin
                step(mk_in(0, j < 100, 0, 8'd0, 1, j == 55), idle_exp(cur, 1), "fault", j);
            end else if (j <= 70) begin
                step(mk_in(0, j < 100, 0, 8'd0, 0, 0), idle_exp(cur, 1), "fault_held", j);
            end else if (j == 71) begin
                step(mk_in(0, j < 100, 0, 8'd0, 0, 1), idle_exp(cur, 0), "fault_clr", j);
            end else begin
                step(mk_in(0, j < 100, 0, 8'd0, 0, 0), idle_exp(cur, 0), "post_clr_idle", j);
            end
        end
        run_period(cur, 1'b0, 8'd0, 0, "resume");

        // Early edge at k=150 while LS is on: HS held off for the dead time.
        for (int j = 0; j < 150; j++) step(mk_in(0, j < 100, 0, 8'd0, 0, 0), run_exp(j, cur), "pre_early", j);
        for (int m = 0; m < PER; m++) begin
            e = run_exp(m, cur);
            if (m < DT) e.hs = 1'b0;
            step(mk_in(0, m < 100, 0, 8'd0, 0, 0), e, "early_edge", m);
        end
        run_period(cur, 1'b0, 8'd0, 0, "after_early");

        // Reset during LS at k=150.
        for (int j = 0; j <= 150; j++) step(mk_in(0, j < 100, 0, 8'd0, 0, 0), run_exp(j, cur), "pre_reset", j);
        step(mk_in(1, 0, 0, 8'd0, 0, 0), idle_exp(8'd0, 0), "mid_reset", 151);
        for (int j = 152; j < PER; j++) step(mk_in(0, 0, 0, 8'd0, 0, 0), idle_exp(8'd0, 0), "post_reset", j);
        run_period(8'd0, 1'b0, 8'd0, 0, "resume_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
